// File: rtl/ceespu_hazard_ctrl.sv
// ceespu_hazard_ctrl
// -----------------------------------------------------------------------------
// Hazard and forwarding controller for the ceespu pipeline. It sits between
// fetch/decode and execute and keeps a short scoreboard of in-flight
// destination registers. For every source operand of the instruction that is
// entering decode it picks the youngest in-flight producer, registers that
// choice as a forwarding select, and muxes forwarded data into the ALU
// operands. If the youngest producer is a load whose data is not yet
// available, it stalls fetch/decode and asks decode to issue a bubble.
//
// Parameters
//   REG_ADDR_W  register index width
//   DATA_W      datapath width
//   NUM_SRC     source operands per instruction
//   FWD_DEPTH   downstream stages tracked (stage 0 = execute output)
//   LOAD_LAT    first stage index at which load data is valid
//   SEL_W       forward-select width (derived)
//
// Ports
//   I_clk, I_rst_n        clock (rising edge), async active-low reset
//   I_stall_ext           execute/dmem busy, freezes all state
//   I_flush               taken branch this cycle
//   I_issue_*             instruction leaving decode into execute
//   I_next_valid/_src     instruction entering decode and its sources
//   I_dec_data            regfile reads for the instruction in decode
//   I_stage_data          result of each tracked downstream stage
//   O_opnd                forwarded operands to execute
//   O_fwd_sel             registered selects (0 = regfile, s = stage s-1)
//   O_stall, O_bubble     hold fetch/decode, issue a NOP next cycle
//
// Optional feature: define CEESPU_HAZARD_STATS_EN to add the saturating
// 32-bit event counters O_luse_cnt (bubble cycles) and O_fwd_cnt (select
// updates that forward at least one operand).
// -----------------------------------------------------------------------------
module ceespu_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_stall_ext,
    input  logic                          I_flush,
    input  logic                          I_issue_valid,
    input  logic                          I_issue_we,
    input  logic                          I_issue_load,
    input  logic [REG_ADDR_W-1:0]         I_issue_regD,
    input  logic                          I_next_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] I_next_src,
    input  logic [NUM_SRC*DATA_W-1:0]     I_dec_data,
    input  logic [FWD_DEPTH*DATA_W-1:0]   I_stage_data,
    output logic [NUM_SRC*DATA_W-1:0]     O_opnd,
    output logic [NUM_SRC*SEL_W-1:0]      O_fwd_sel,
    output logic                          O_stall,
    output logic                          O_bubble
`ifdef CEESPU_HAZARD_STATS_EN
    ,
    output logic [31:0]                   O_luse_cnt,
    output logic [31:0]                   O_fwd_cnt
`endif
);

    logic                  sbValid [FWD_DEPTH];
    logic                  sbWe    [FWD_DEPTH];
    logic                  sbLoad  [FWD_DEPTH];
    logic [REG_ADDR_W-1:0] sbRegD  [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] fwdSel;
    logic [NUM_SRC*SEL_W-1:0] newSel;
    logic                     hazard;
    logic                     selUpdate;

    // Producer search for each source operand. Candidates are scanned oldest
    // first so that a younger match simply overwrites an older one; the
    // issuing instruction is the youngest of all. stageIdx is the stage the
    // producer will occupy when the consumer reaches execute minus one, so a
    // load is only usable once stageIdx has reached LOAD_LAT.
    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        logic [SEL_W-1:0]      selI;
        logic                  matchLoad;
        int                    stageIdx;
        newSel = '0;
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src       = I_next_src[i*REG_ADDR_W +: REG_ADDR_W];
            selI      = '0;
            matchLoad = 1'b0;
            stageIdx  = 0;
            for (int j = FWD_DEPTH - 2; j >= 0; j--) begin
                if (I_next_valid && sbValid[j] && sbWe[j] && (sbRegD[j] == src)) begin
                    selI      = SEL_W'(j + 2);
                    matchLoad = sbLoad[j];
                    stageIdx  = j + 1;
                end
            end
            if (I_next_valid && I_issue_valid && I_issue_we && (I_issue_regD == src)) begin
                selI      = SEL_W'(1);
                matchLoad = I_issue_load;
                stageIdx  = 0;
            end
            if (matchLoad && (stageIdx < LOAD_LAT)) begin
                hazard = 1'b1;
            end
            newSel[i*SEL_W +: SEL_W] = selI;
        end
    end

    // Reset wins immediately over any pending hazard, and a flush cancels
    // the stall because the instruction in decode is being discarded.
    assign O_stall   = I_rst_n & (I_stall_ext | (hazard & ~I_flush));
    assign O_bubble  = I_rst_n & hazard & ~I_stall_ext & ~I_flush;
    assign selUpdate = ~I_flush & ~I_stall_ext & ~hazard;

    // Scoreboard shift register. A flush always kills the instruction just
    // issued into execute, even while the pipe is frozen; the older entries
    // only move when the pipe advances.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sbValid[k] <= 1'b0;
                sbWe[k]    <= 1'b0;
                sbLoad[k]  <= 1'b0;
                sbRegD[k]  <= '0;
            end
        end else if (!I_stall_ext) begin
            sbValid[0] <= I_issue_valid & ~I_flush;
            sbWe[0]    <= I_issue_we;
            sbLoad[0]  <= I_issue_load;
            sbRegD[0]  <= I_issue_regD;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                sbValid[k] <= sbValid[k-1];
                sbWe[k]    <= sbWe[k-1];
                sbLoad[k]  <= sbLoad[k-1];
                sbRegD[k]  <= sbRegD[k-1];
            end
        end else if (I_flush) begin
            sbValid[0] <= 1'b0;
        end
    end

    // Forward selects are captured when the consumer moves into decode and
    // held while it waits there; during a load-use stall they keep the old
    // value until the load has progressed far enough.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            fwdSel <= '0;
        end else if (I_flush) begin
            fwdSel <= '0;
        end else if (selUpdate) begin
            fwdSel <= newSel;
        end
    end

    assign O_fwd_sel = fwdSel;

    // Operand mux: regfile value unless a select points at a stage result.
    always_comb begin
        O_opnd = I_dec_data;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (fwdSel[i*SEL_W +: SEL_W] == SEL_W'(k + 1)) begin
                    O_opnd[i*DATA_W +: DATA_W] = I_stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef CEESPU_HAZARD_STATS_EN
    logic [31:0] luseCnt;
    logic [31:0] fwdCnt;

    // Saturating event counters: bubble cycles and select updates that
    // forward at least one operand.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            luseCnt <= '0;
            fwdCnt  <= '0;
        end else begin
            if (O_bubble && (luseCnt != 32'hFFFF_FFFF)) begin
                luseCnt <= luseCnt + 32'd1;
            end
            if (selUpdate && (|newSel) && (fwdCnt != 32'hFFFF_FFFF)) begin
                fwdCnt <= fwdCnt + 32'd1;
            end
        end
    end

    assign O_luse_cnt = luseCnt;
    assign O_fwd_cnt  = fwdCnt;
`endif

endmodule

// File: tb/tb_ceespu_hazard_ctrl.sv
// tb_ceespu_hazard_ctrl
// -----------------------------------------------------------------------------
// Bench for ceespu_hazard_ctrl. dut drives the default configuration
// (FWD_DEPTH=2, LOAD_LAT=1) through a table of per-cycle vectors; dut2 uses
// FWD_DEPTH=3, LOAD_LAT=2 for the longer load-use stall. Both share the
// control inputs. Expected selects are queued when a vector is driven and
// compared after the clock edge that captures them.
// -----------------------------------------------------------------------------
module tb_ceespu_hazard_ctrl;

    localparam logic [31:0] DEC0   = 32'hD0D0_D0D0;
    localparam logic [31:0] DEC1   = 32'hD1D1_D1D1;
    localparam logic [31:0] STG0   = 32'h0000_1234;
    localparam logic [31:0] STG1   = 32'hDEAD_BEEF;
    localparam logic [31:0] STG2   = 32'hCAFE_F00D;
    localparam int          NUMVEC = 20;

    typedef struct {
        logic       iv;
        logic       iwe;
        logic       ild;
        logic [4:0] ird;
        logic       nv;
        logic [4:0] s0;
        logic [4:0] s1;
        logic       fl;
        logic       se;
        logic       eStall;
        logic       eBub;
        logic [1:0] eSel0;
        logic [1:0] eSel1;
    } vec_t;

    typedef struct {
        int         row;
        logic [1:0] sel0;
        logic [1:0] sel1;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        stallExt;
    logic        flush;
    logic        issueValid;
    logic        issueWe;
    logic        issueLoad;
    logic [4:0]  issueRegD;
    logic        nextValid;
    logic [9:0]  nextSrc;
    logic [63:0] decData;
    logic [63:0] stageData;
    logic [95:0] stageData2;
    logic [63:0] opnd;
    logic [63:0] opnd2;
    logic [3:0]  fwdSel;
    logic [3:0]  fwdSel2;
    logic        stall;
    logic        bubble;
    logic        stall2;
    logic        bubble2;
`ifdef CEESPU_HAZARD_STATS_EN
    logic [31:0] luseCnt;
    logic [31:0] fwdCnt;
    logic [31:0] luseCnt2;
    logic [31:0] fwdCnt2;
`endif

    int   checks;
    int   failures;
    vec_t vecs [NUMVEC];
    exp_t expQ [$];

    ceespu_hazard_ctrl dut (
        .I_clk         (clk),
        .I_rst_n       (rstN),
        .I_stall_ext   (stallExt),
        .I_flush       (flush),
        .I_issue_valid (issueValid),
        .I_issue_we    (issueWe),
        .I_issue_load  (issueLoad),
        .I_issue_regD  (issueRegD),
        .I_next_valid  (nextValid),
        .I_next_src    (nextSrc),
        .I_dec_data    (decData),
        .I_stage_data  (stageData),
        .O_opnd        (opnd),
        .O_fwd_sel     (fwdSel),
        .O_stall       (stall),
        .O_bubble      (bubble)
`ifdef CEESPU_HAZARD_STATS_EN
        ,
        .O_luse_cnt    (luseCnt),
        .O_fwd_cnt     (fwdCnt)
`endif
    );

    ceespu_hazard_ctrl #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut2 (
        .I_clk         (clk),
        .I_rst_n       (rstN),
        .I_stall_ext   (stallExt),
        .I_flush       (flush),
        .I_issue_valid (issueValid),
        .I_issue_we    (issueWe),
        .I_issue_load  (issueLoad),
        .I_issue_regD  (issueRegD),
        .I_next_valid  (nextValid),
        .I_next_src    (nextSrc),
        .I_dec_data    (decData),
        .I_stage_data  (stageData2),
        .O_opnd        (opnd2),
        .O_fwd_sel     (fwdSel2),
        .O_stall       (stall2),
        .O_bubble      (bubble2)
`ifdef CEESPU_HAZARD_STATS_EN
        ,
        .O_luse_cnt    (luseCnt2),
        .O_fwd_cnt     (fwdCnt2)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic iwe, input logic ild,
                                input int ird, input logic nv, input int s0,
                                input int s1, input logic fl, input logic se,
                                input logic eStall, input logic eBub,
                                input int eSel0, input int eSel1);
        vec_t v;
        v.iv     = iv;
        v.iwe    = iwe;
        v.ild    = ild;
        v.ird    = 5'(ird);
        v.nv     = nv;
        v.s0     = 5'(s0);
        v.s1     = 5'(s1);
        v.fl     = fl;
        v.se     = se;
        v.eStall = eStall;
        v.eBub   = eBub;
        v.eSel0  = 2'(eSel0);
        v.eSel1  = 2'(eSel1);
        return v;
    endfunction

    // Reference operand for a given select in the default configuration.
    function automatic logic [31:0] opndModel(input logic [1:0] sel, input int op);
        case (sel)
            2'd1:    return STG0;
            2'd2:    return STG1;
            default: return (op == 0) ? DEC0 : DEC1;
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v);
        issueValid = v.iv;
        issueWe    = v.iwe;
        issueLoad  = v.ild;
        issueRegD  = v.ird;
        nextValid  = v.nv;
        nextSrc    = {v.s1, v.s0};
        flush      = v.fl;
        stallExt   = v.se;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        checks     = 0;
        failures   = 0;
        clk        = 1'b0;
        rstN       = 1'b0;
        decData    = {DEC1, DEC0};
        stageData  = {STG1, STG0};
        stageData2 = {STG2, STG1, STG0};

        // Idle         iv we ld rd nv s0 s1 fl se | st bu s0 s1
        vecs[0]  = mk(0, 0, 0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 0);
        // Back-to-back ALU: r3 issuing, consumer reads r3
        vecs[1]  = mk(1, 1, 0, 3,  1, 3,  0,  0, 0,  0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 0, 5,  1, 1,  2,  0, 0,  0, 0, 0, 0);
        // r5 one instruction further down
        vecs[3]  = mk(1, 1, 0, 6,  1, 0,  5,  0, 0,  0, 0, 0, 2);
        // r5 issuing again: youngest wins
        vecs[4]  = mk(1, 1, 0, 5,  1, 6,  5,  0, 0,  0, 0, 2, 1);
        // Load r7 with dependent consumer: one stall, selects held
        vecs[5]  = mk(1, 1, 1, 7,  1, 7,  0,  0, 0,  1, 1, 2, 1);
        vecs[6]  = mk(0, 0, 0, 0,  1, 7,  0,  0, 0,  0, 0, 2, 0);
        // External stall over a load-use match: frozen, no bubble
        vecs[7]  = mk(1, 1, 1, 8,  1, 8,  0,  0, 1,  1, 0, 2, 0);
        vecs[8]  = mk(1, 1, 1, 8,  1, 8,  0,  0, 1,  1, 0, 2, 0);
        vecs[9]  = mk(1, 1, 1, 8,  1, 8,  0,  0, 1,  1, 0, 2, 0);
        // Load r8 never entered the scoreboard
        vecs[10] = mk(1, 1, 0, 9,  1, 8,  9,  0, 0,  0, 0, 0, 1);
        // Flush during a load-use match
        vecs[11] = mk(1, 1, 1, 10, 1, 10, 9,  1, 0,  0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0,  1, 10, 9,  0, 0,  0, 0, 0, 0);
        // Flush while externally stalled clears selects and entry 0
        vecs[13] = mk(1, 1, 0, 11, 1, 11, 0,  0, 0,  0, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 0,  1, 11, 0,  1, 1,  1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0,  1, 11, 0,  0, 0,  0, 0, 0, 0);
        // No write enable / consumer invalid: no forwarding
        vecs[16] = mk(1, 0, 0, 12, 1, 12, 12, 0, 0,  0, 0, 0, 0);
        vecs[17] = mk(1, 1, 0, 13, 0, 13, 13, 0, 0,  0, 0, 0, 0);
        // Load one instruction ahead is already usable
        vecs[18] = mk(1, 1, 1, 14, 1, 13, 0,  0, 0,  0, 0, 2, 0);
        vecs[19] = mk(0, 0, 0, 0,  1, 14, 13, 0, 0,  0, 0, 2, 0);

        // Reset state, with a load-use pattern on the inputs
        applyStimulus(mk(1, 1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0));
        #12;
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.bubble", 32'(bubble), 32'd0);
        checkOutput("reset.fwdSel", 32'(fwdSel), 32'd0);
        checkOutput("reset.opnd0", opnd[31:0], DEC0);
        checkOutput("reset.opnd1", opnd[63:32], DEC1);
        applyStimulus(vecs[0]);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NUMVEC; i++) begin
            applyStimulus(vecs[i]);
            e.row  = i;
            e.sel0 = vecs[i].eSel0;
            e.sel1 = vecs[i].eSel1;
            expQ.push_back(e);
            #3;
            checkOutput($sformatf("row%0d.stall", i), 32'(stall), 32'(vecs[i].eStall));
            checkOutput($sformatf("row%0d.bubble", i), 32'(bubble), 32'(vecs[i].eBub));
            @(posedge clk);
            #1;
            e = expQ.pop_front();
            checkOutput($sformatf("row%0d.sel0", e.row), 32'(fwdSel[1:0]), 32'(e.sel0));
            checkOutput($sformatf("row%0d.sel1", e.row), 32'(fwdSel[3:2]), 32'(e.sel1));
            checkOutput($sformatf("row%0d.opnd0", e.row), opnd[31:0], opndModel(e.sel0, 0));
            checkOutput($sformatf("row%0d.opnd1", e.row), opnd[63:32], opndModel(e.sel1, 1));
        end

`ifdef CEESPU_HAZARD_STATS_EN
        checkOutput("stats.luseCnt", luseCnt, 32'd1);
        checkOutput("stats.fwdCnt", fwdCnt, 32'd8);
`endif

        // Reset asserted in the middle of a load-use stall
        applyStimulus(mk(1, 1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checkOutput("midReset.stallBefore", 32'(stall), 32'd1);
        checkOutput("midReset.bubbleBefore", 32'(bubble), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midReset.stall", 32'(stall), 32'd0);
        checkOutput("midReset.bubble", 32'(bubble), 32'd0);
        checkOutput("midReset.fwdSel", 32'(fwdSel), 32'd0);
        checkOutput("midReset.opnd0", opnd[31:0], DEC0);
        applyStimulus(vecs[0]);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Two-cycle load-use stall with LOAD_LAT=2, FWD_DEPTH=3
        applyStimulus(mk(1, 1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checkOutput("lat2.stallCycle1", 32'(stall2), 32'd1);
        checkOutput("lat2.bubbleCycle1", 32'(bubble2), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checkOutput("lat2.stallCycle2", 32'(stall2), 32'd1);
        checkOutput("lat2.bubbleCycle2", 32'(bubble2), 32'd1);
        checkOutput("lat2.selHeld", 32'(fwdSel2[1:0]), 32'd0);
        @(posedge clk);
        #4;
        checkOutput("lat2.stallCycle3", 32'(stall2), 32'd0);
        checkOutput("lat2.bubbleCycle3", 32'(bubble2), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat2.sel0", 32'(fwdSel2[1:0]), 32'd3);
        checkOutput("lat2.opnd0", opnd2[31:0], STG2);
`ifdef CEESPU_HAZARD_STATS_EN
        checkOutput("lat2.luseCnt", luseCnt2, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
